// File: rtl/reg_trace_multi.sv
// reg_trace_multi: byte-wide register block holding per-rule trace pattern/mask shadows,
// committed atomically to the live outputs. Per-rule match counters exist only with TRACE_MATCH_COUNT_EN.
module reg_trace_multi #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pBUFFER_SIZE  = 64,
  parameter int pMATCH_RULES  = 8,
  parameter int pCOUNT_WIDTH  = 16
) (
  input  logic                                   usb_clk,
  input  logic                                   reset_n,
  input  logic [pADDR_WIDTH-1:pBYTECNT_SIZE]     reg_address,
  input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  input  logic                                   reg_read,
  input  logic                                   reg_write,
  input  logic                                   reg_addrvalid,
  input  logic [7:0]                             write_data,
  output logic [7:0]                             read_data,
  input  logic [pMATCH_RULES-1:0]                I_match_pulse,
  input  logic                                   I_synchronized,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_pattern,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_mask,
  output logic [pMATCH_RULES-1:0]                O_pattern_enable,
  output logic [2:0]                             O_trace_width,
  output logic                                   O_commit_pulse
);
  localparam int AW     = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int NBYTES = pBUFFER_SIZE / 8;
  localparam int EBYTES = (pMATCH_RULES + 7) / 8;

  localparam logic [AW-1:0] A_REV         = AW'(0);
  localparam logic [AW-1:0] A_RULE_SEL    = AW'(1);
  localparam logic [AW-1:0] A_PATTERN     = AW'(2);
  localparam logic [AW-1:0] A_MASK        = AW'(3);
  localparam logic [AW-1:0] A_COMMIT      = AW'(4);
  localparam logic [AW-1:0] A_PAT_ENABLE  = AW'(5);
  localparam logic [AW-1:0] A_COUNT       = AW'(6);
  localparam logic [AW-1:0] A_COUNT_CLEAR = AW'(7);
  localparam logic [AW-1:0] A_TRACE_WIDTH = AW'(8);
  localparam logic [AW-1:0] A_STATUS      = AW'(9);

  // Bus protocol: an access happens only in a cycle where reg_addrvalid is high together with
  // reg_write (write acts at that edge) or reg_read (read_data valid for the following cycle only).
  logic                    wr_en, rd_en, sh_wr, commit_wr, pending;
  logic [3:0]              rule_sel;
  logic [31:0]             sel_w, byte_w;
  logic [7:0]              rd_val, count_rd_val;
  logic [pBUFFER_SIZE-1:0] sh_pat [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] sh_mask [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] live_pat [pMATCH_RULES];
  logic [pBUFFER_SIZE-1:0] live_mask [pMATCH_RULES];

  assign wr_en     = reg_addrvalid & reg_write;
  assign rd_en     = reg_addrvalid & reg_read;
  assign sel_w     = 32'(rule_sel);
  assign byte_w    = 32'(reg_bytecnt);
  assign sh_wr     = wr_en && (reg_address == A_PATTERN || reg_address == A_MASK) &&
                     (sel_w < pMATCH_RULES) && (byte_w < NBYTES);
  assign commit_wr = wr_en && (reg_address == A_COMMIT);

  always_comb begin
    for (int r = 0; r < pMATCH_RULES; r++) begin
      O_trace_pattern[r*pBUFFER_SIZE +: pBUFFER_SIZE] = live_pat[r];
      O_trace_mask[r*pBUFFER_SIZE +: pBUFFER_SIZE]    = live_mask[r];
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (reg_address)
      A_REV:         rd_val = 8'h01;
      A_RULE_SEL:    rd_val = {4'h0, rule_sel};
      A_PATTERN, A_MASK: begin
        // Loop bounds cover only valid rule/byte slots, so out-of-range selects read 0.
        for (int r = 0; r < pMATCH_RULES; r++)
          for (int b = 0; b < NBYTES; b++)
            if (sel_w == r && byte_w == b)
              rd_val = (reg_address == A_PATTERN) ? sh_pat[r][b*8 +: 8] : sh_mask[r][b*8 +: 8];
      end
      A_PAT_ENABLE: begin
        for (int b = 0; b < EBYTES; b++)
          for (int j = 0; j < 8; j++)
            if (byte_w == b && b*8 + j < pMATCH_RULES) rd_val[j] = O_pattern_enable[b*8 + j];
      end
      A_COUNT:       rd_val = count_rd_val;
      A_TRACE_WIDTH: rd_val = {5'h00, O_trace_width};
      A_STATUS:      rd_val = {6'h00, pending, I_synchronized};
      default:       rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        sh_pat[r]    <= '0;
        sh_mask[r]   <= '1;
        live_pat[r]  <= '0;
        live_mask[r] <= '1;
      end
      O_pattern_enable <= '0;
      O_trace_width    <= 3'd4;
      rule_sel         <= 4'h0;
      pending          <= 1'b0;
      O_commit_pulse   <= 1'b0;
      read_data        <= 8'h00;
    end else begin
      O_commit_pulse <= commit_wr;
      read_data      <= rd_en ? rd_val : 8'h00;
      // A shadow write outranks a same-cycle commit so the new byte is never lost.
      if (sh_wr)          pending <= 1'b1;
      else if (commit_wr) pending <= 1'b0;
      if (commit_wr) begin
        for (int r = 0; r < pMATCH_RULES; r++) begin
          live_pat[r]  <= sh_pat[r];
          live_mask[r] <= sh_mask[r];
        end
      end
      if (wr_en) begin
        case (reg_address)
          A_RULE_SEL:    rule_sel <= write_data[3:0];
          A_PATTERN, A_MASK: begin
            for (int r = 0; r < pMATCH_RULES; r++)
              for (int b = 0; b < NBYTES; b++)
                if (sel_w == r && byte_w == b) begin
                  if (reg_address == A_PATTERN) sh_pat[r][b*8 +: 8]  <= write_data;
                  else                          sh_mask[r][b*8 +: 8] <= write_data;
                end
          end
          A_PAT_ENABLE: begin
            for (int b = 0; b < EBYTES; b++)
              for (int j = 0; j < 8; j++)
                if (byte_w == b && b*8 + j < pMATCH_RULES) O_pattern_enable[b*8 + j] <= write_data[j];
          end
          A_TRACE_WIDTH: O_trace_width <= write_data[2:0];
          default: ;
        endcase
      end
    end
  end

`ifdef TRACE_MATCH_COUNT_EN
  localparam int CBYTES = pCOUNT_WIDTH / 8;
  logic [pCOUNT_WIDTH-1:0] cnt [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0] snap, cnt_sel;
  logic                    clr_wr, snap_rd;

  assign clr_wr  = wr_en && (reg_address == A_COUNT_CLEAR);
  assign snap_rd = rd_en && (reg_address == A_COUNT) && (byte_w == 0);

  always_comb begin
    cnt_sel = '0;
    for (int r = 0; r < pMATCH_RULES; r++)
      if (sel_w == r) cnt_sel = cnt[r];
  end

  // Byte 0 returns the value being latched; higher bytes come from that same latched copy.
  always_comb begin
    count_rd_val = 8'h00;
    if (byte_w == 0) count_rd_val = cnt_sel[7:0];
    else
      for (int b = 1; b < CBYTES; b++)
        if (byte_w == b) count_rd_val = snap[b*8 +: 8];
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < pMATCH_RULES; r++) cnt[r] <= '0;
      snap <= '0;
    end else begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (clr_wr && byte_w == r / 8 && write_data[r % 8]) cnt[r] <= '0;
        else if (I_match_pulse[r] && cnt[r] != '1)         cnt[r] <= cnt[r] + pCOUNT_WIDTH'(1);
      end
      if (snap_rd) snap <= cnt_sel;
    end
  end
`else
  logic unused_match;
  assign unused_match = ^I_match_pulse;
  assign count_rd_val = 8'h00;
`endif

endmodule

// File: tb/tb_reg_trace_multi.sv
// Bench for reg_trace_multi: register table vectors, directed multi-cycle sequences and
// randomized accesses checked against a spec-level model of the register file.
module tb_reg_trace_multi;
  localparam int AW = 21, BW = 7, BUF = 64, RULES = 8, CW = 16;
  localparam int RA = AW - BW;

  logic                    usb_clk, reset_n;
  logic [AW-1:BW]          reg_address;
  logic [BW-1:0]           reg_bytecnt;
  logic                    reg_read, reg_write, reg_addrvalid;
  logic [7:0]              write_data, read_data;
  logic [RULES-1:0]        I_match_pulse;
  logic                    I_synchronized;
  logic [RULES*BUF-1:0]    O_trace_pattern, O_trace_mask;
  logic [RULES-1:0]        O_pattern_enable;
  logic [2:0]              O_trace_width;
  logic                    O_commit_pulse;

  reg_trace_multi #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW), .pBUFFER_SIZE(BUF),
                    .pMATCH_RULES(RULES), .pCOUNT_WIDTH(CW)) dut (
    .usb_clk(usb_clk), .reset_n(reset_n), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .write_data(write_data), .read_data(read_data), .I_match_pulse(I_match_pulse),
    .I_synchronized(I_synchronized), .O_trace_pattern(O_trace_pattern), .O_trace_mask(O_trace_mask),
    .O_pattern_enable(O_pattern_enable), .O_trace_width(O_trace_width), .O_commit_pulse(O_commit_pulse)
  );

  // Clock / reset
  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(string name, logic [BUF-1:0] act, logic [BUF-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model of the register file
  logic [BUF-1:0]   m_sh_pat [RULES];
  logic [BUF-1:0]   m_sh_mask [RULES];
  logic [BUF-1:0]   m_live_pat [RULES];
  logic [BUF-1:0]   m_live_mask [RULES];
  logic [RULES-1:0] m_en;
  logic [3:0]       m_sel;
  logic [2:0]       m_width;
  logic             m_pend;

  function automatic void m_reset();
    for (int r = 0; r < RULES; r++) begin
      m_sh_pat[r] = '0; m_live_pat[r] = '0;
      m_sh_mask[r] = '1; m_live_mask[r] = '1;
    end
    m_en = '0; m_sel = 4'h0; m_width = 3'd4; m_pend = 1'b0;
  endfunction

  function automatic void m_write(int a, int bc, logic [7:0] d);
    case (a)
      1: m_sel = d[3:0];
      2, 3: if (m_sel < RULES && bc < BUF/8) begin
        if (a == 2) m_sh_pat[m_sel][bc*8 +: 8] = d;
        else        m_sh_mask[m_sel][bc*8 +: 8] = d;
        m_pend = 1'b1;
      end
      4: begin
        for (int r = 0; r < RULES; r++) begin
          m_live_pat[r] = m_sh_pat[r]; m_live_mask[r] = m_sh_mask[r];
        end
        m_pend = 1'b0;
      end
      5: for (int j = 0; j < 8; j++) if (bc*8 + j < RULES) m_en[bc*8 + j] = d[j];
      8: m_width = d[2:0];
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] m_read(int a, int bc);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      0: v = 8'h01;
      1: v = {4'h0, m_sel};
      2: if (m_sel < RULES && bc < BUF/8) v = m_sh_pat[m_sel][bc*8 +: 8];
      3: if (m_sel < RULES && bc < BUF/8) v = m_sh_mask[m_sel][bc*8 +: 8];
      5: if (bc == 0) v = m_en;
      8: v = {5'h00, m_width};
      9: v = {6'h00, m_pend, I_synchronized};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Driver tasks
  task automatic do_reset();
    reg_addrvalid = 0; reg_read = 0; reg_write = 0; write_data = 0;
    reg_address = '0; reg_bytecnt = '0; I_match_pulse = '0;
    @(negedge usb_clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge usb_clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic bus_write(int a, int bc, logic [7:0] d);
    @(negedge usb_clk);
    reg_address = RA'(a); reg_bytecnt = BW'(bc); write_data = d;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    @(posedge usb_clk); #1;
    reg_addrvalid = 1'b0; reg_write = 1'b0;
    m_write(a, bc, d);
  endtask

  task automatic bus_read(int a, int bc, output logic [7:0] d);
    @(negedge usb_clk);
    reg_address = RA'(a); reg_bytecnt = BW'(bc);
    reg_addrvalid = 1'b1; reg_read = 1'b1;
    @(posedge usb_clk); #1;
    reg_addrvalid = 1'b0; reg_read = 1'b0;
    d = read_data;
  endtask

  task automatic read_check(string name, int a, int bc, logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    bus_read(a, bc, got);
    check(name, BUF'(got), BUF'(exp_q.pop_front()));
  endtask

  task automatic pulse_rule(int r, int n);
    @(negedge usb_clk);
    I_match_pulse[r] = 1'b1;
    repeat (n) @(negedge usb_clk);
    I_match_pulse = '0;
  endtask

  task automatic check_outputs(string tag);
    for (int r = 0; r < RULES; r++) begin
      check($sformatf("%s_pat%0d", tag, r), O_trace_pattern[r*BUF +: BUF], m_live_pat[r]);
      check($sformatf("%s_mask%0d", tag, r), O_trace_mask[r*BUF +: BUF], m_live_mask[r]);
    end
    check({tag, "_en"}, BUF'(O_pattern_enable), BUF'(m_en));
    check({tag, "_width"}, BUF'(O_trace_width), BUF'(m_width));
  endtask

  // Table vectors
  typedef struct {
    int         a;
    int         bc;
    bit         wr;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[17];

  initial begin
    logic [7:0] got;
    reset_n = 1'b1;
    I_synchronized = 1'b0;
    tbl[0]  = '{0, 0, 1'b0, 8'h00, 8'h01};
    tbl[1]  = '{1, 0, 1'b1, 8'h05, 8'h00};
    tbl[2]  = '{1, 0, 1'b0, 8'h00, 8'h05};
    tbl[3]  = '{1, 0, 1'b1, 8'hF3, 8'h00};
    tbl[4]  = '{1, 0, 1'b0, 8'h00, 8'h03};
    tbl[5]  = '{8, 0, 1'b1, 8'hFA, 8'h00};
    tbl[6]  = '{8, 0, 1'b0, 8'h00, 8'h02};
    tbl[7]  = '{5, 0, 1'b1, 8'hA5, 8'h00};
    tbl[8]  = '{5, 0, 1'b0, 8'h00, 8'hA5};
    tbl[9]  = '{5, 1, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{0, 0, 1'b1, 8'h55, 8'h00};
    tbl[11] = '{0, 0, 1'b0, 8'h00, 8'h01};
    tbl[12] = '{4, 0, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{12, 0, 1'b0, 8'h00, 8'h00};
    tbl[14] = '{3, 2, 1'b1, 8'h5A, 8'h00};
    tbl[15] = '{3, 2, 1'b0, 8'h00, 8'h5A};
    tbl[16] = '{3, 8, 1'b0, 8'h00, 8'h00};

    // Reset state
    do_reset();
    check_outputs("reset");
    check("reset_commit", BUF'(O_commit_pulse), '0);
    check("reset_rdata", BUF'(read_data), '0);
    read_check("rev", 0, 0, 8'h01);
    @(posedge usb_clk); #1;
    check("rdata_idle", BUF'(read_data), '0);

    // Register table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].bc, tbl[i].d);
      else read_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].bc, tbl[i].exp);
    end
    check_outputs("tbl");

    // Shadow pattern then commit on rule 3
    do_reset();
    bus_write(1, 0, 8'h03);
    for (int b = 0; b < 8; b++) bus_write(2, b, 8'(8'h11 * (b + 1)));
    check("pat3_pre_commit", O_trace_pattern[3*BUF +: BUF], 64'h0);
    read_check("status_pending", 9, 0, 8'h02);
    bus_write(4, 0, 8'h00);
    check("commit_pulse_hi", BUF'(O_commit_pulse), BUF'(1));
    check("pat3_committed", O_trace_pattern[3*BUF +: BUF], 64'h8877665544332211);
    @(posedge usb_clk); #1;
    check("commit_pulse_lo", BUF'(O_commit_pulse), '0);
    read_check("status_clear", 9, 0, 8'h00);

    // Out-of-range rule select
    bus_write(1, 0, 8'h09);
    bus_write(2, 0, 8'hAB);
    read_check("sel9_read", 2, 0, 8'h00);
    read_check("sel9_status", 9, 0, 8'h00);
    bus_write(1, 0, 8'h03);
    read_check("sel3_shadow_kept", 2, 0, 8'h11);

`ifdef TRACE_MATCH_COUNT_EN
    // Saturation and clear-beats-pulse on rule 2
    pulse_rule(2, 16'hFFFE + 5);
    bus_write(1, 0, 8'h02);
    read_check("cnt_sat_b0", 6, 0, 8'hFF);
    read_check("cnt_sat_b1", 6, 1, 8'hFF);
    I_match_pulse[2] = 1'b1;
    bus_write(7, 0, 8'h04);
    I_match_pulse = '0;
    read_check("cnt_clr_b0", 6, 0, 8'h00);
    read_check("cnt_clr_b1", 6, 1, 8'h00);
    // Snapshot holds the upper byte across a carry
    pulse_rule(2, 255);
    read_check("snap_b0", 6, 0, 8'hFF);
    pulse_rule(2, 1);
    read_check("snap_b1", 6, 1, 8'h00);
    read_check("snap2_b0", 6, 0, 8'h00);
    read_check("snap2_b1", 6, 1, 8'h01);
    read_check("cnt_b2", 6, 2, 8'h00);
`else
    pulse_rule(2, 10);
    bus_write(1, 0, 8'h02);
    read_check("nocnt_b0", 6, 0, 8'h00);
    read_check("nocnt_b1", 6, 1, 8'h00);
`endif

    // Reset in the middle of a multi-byte mask write
    bus_write(1, 0, 8'h03);
    for (int b = 0; b < 4; b++) bus_write(3, b, 8'h00);
    @(negedge usb_clk);
    reg_address = RA'(3); reg_bytecnt = BW'(4); write_data = 8'h00;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async_pat3", O_trace_pattern[3*BUF +: BUF], 64'h0);
    check("async_mask3", O_trace_mask[3*BUF +: BUF], '1);
    check("async_width", BUF'(O_trace_width), BUF'(4));
    check("async_commit", BUF'(O_commit_pulse), '0);
    check("async_rdata", BUF'(read_data), '0);
    reg_addrvalid = 1'b0; reg_write = 1'b0;
    @(negedge usb_clk);
    reset_n = 1'b1;
    m_reset();
    read_check("post_rst_status", 9, 0, 8'h00);
    read_check("post_rst_sel", 1, 0, 8'h00);
    bus_write(1, 0, 8'h03);
    read_check("post_rst_mask_b0", 3, 0, 8'hFF);
    bus_write(4, 0, 8'h00);
    check_outputs("post_rst");

    // Randomized accesses against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int op, a, bc;
      logic [7:0] d, exp;
      op = $urandom_range(0, 3);
      bc = $urandom_range(0, 9);
      d  = 8'($urandom);
      I_synchronized = 1'($urandom_range(0, 1));
      if (op == 0) begin
        bus_write(1, 0, 8'($urandom_range(0, 11)));
        check_outputs("rnd_sel");
      end else if (op == 1) begin
        a = $urandom_range(2, 3);
        bus_write(a, bc, d);
        check("rnd_shadow_pulse", BUF'(O_commit_pulse), '0);
      end else if (op == 2) begin
        a = $urandom_range(0, 15);
        if (a == 6) a = 9;
        exp = m_read(a, bc);
        read_check($sformatf("rnd_read_a%0d_b%0d", a, bc), a, bc, exp);
      end else begin
        a = $urandom_range(0, 15);
        if (a == 6 || a == 7) a = 4;
        bus_write(a, bc, d);
        check("rnd_commit_pulse", BUF'(O_commit_pulse), BUF'(a == 4));
        check_outputs("rnd_wr");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
